// File: rtl/alk_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alk_pkg
// Description : Shared constants and types for the A:Q shift sequencer.
//               Holds op-code values, sequencer state encoding, shift-in
//               source encoding and default WIDTH/CNTW values.
// Revision    : 1.0  initial release
// ============================================================================
package alk_pkg;

  // Default datapath and shift-count widths
  localparam int c_WIDTH_DEFAULT = 32;
  localparam int c_CNTW_DEFAULT  = 6;

  // Operation codes (alushf_h)
  localparam logic [2:0] c_OP_LOAD = 3'b000;
  localparam logic [2:0] c_OP_SHL1 = 3'b001;
  localparam logic [2:0] c_OP_SHF  = 3'b010;
  localparam logic [2:0] c_OP_ROT  = 3'b011;
  localparam logic [2:0] c_OP_QSH1 = 3'b100;
  localparam logic [2:0] c_OP_ASH1 = 3'b101;
  localparam logic [2:0] c_OP_SHR  = 3'b110;
  localparam logic [2:0] c_OP_ASR  = 3'b111;

  // Sequencer states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // Source of the bit entering the vacated end of the shifted field
  typedef enum logic [1:0] {
    SIN_ZERO = 2'd0,
    SIN_ONE  = 2'd1,
    SIN_WRAP = 2'd2,
    SIN_SIGN = 2'd3
  } sin_t;

endpackage : alk_pkg
`default_nettype wire

// File: rtl/alkshfdec.sv
`default_nettype none
// ============================================================================
// Module      : alkshfdec
// Description : Combinational decoder from 3-bit op code to single-step
//               shifter controls.
// Ports       : i_op        - op code (captured op register)
//               o_dir_right - 1: shift toward LSB, 0: toward MSB
//               o_a_en      - A participates in the step
//               o_q_en      - Q participates in the step
//               o_sin       - shift-in source
//               o_no_step   - op performs no step at all
// Revision    : 1.0  initial release
// ============================================================================
module alkshfdec
  import alk_pkg::*;
(
  input  logic [2:0] i_op,
  output logic       o_dir_right,
  output logic       o_a_en,
  output logic       o_q_en,
  output sin_t       o_sin,
  output logic       o_no_step
);

  always_comb begin
    o_dir_right = 1'b0;
    o_a_en      = 1'b0;
    o_q_en      = 1'b0;
    o_sin       = SIN_ZERO;
    o_no_step   = 1'b0;
    case (i_op)
      c_OP_LOAD: o_no_step = 1'b1;
      c_OP_SHL1: begin o_a_en = 1'b1; o_q_en = 1'b1; o_sin = SIN_ONE;  end
      c_OP_SHF:  begin o_a_en = 1'b1; o_q_en = 1'b1; o_sin = SIN_ZERO; end
      c_OP_ROT:  begin o_a_en = 1'b1; o_q_en = 1'b1; o_sin = SIN_WRAP; end
      c_OP_QSH1: begin o_q_en = 1'b1; o_sin = SIN_ONE; end
      c_OP_ASH1: begin o_a_en = 1'b1; o_sin = SIN_ONE; end
      c_OP_SHR: begin
        o_dir_right = 1'b1; o_a_en = 1'b1; o_q_en = 1'b1; o_sin = SIN_ZERO;
      end
      c_OP_ASR: begin
        o_dir_right = 1'b1; o_a_en = 1'b1; o_q_en = 1'b1; o_sin = SIN_SIGN;
      end
      default: o_no_step = 1'b1;
    endcase
  end

endmodule : alkshfdec
`default_nettype wire

// File: rtl/alkshfseq.sv
`default_nettype none
// ============================================================================
// Module      : alkshfseq
// Description : Multi-cycle A:Q shift sequencer. On start, captures operands,
//               op code and step count, then performs one single-bit step per
//               clock until the count is exhausted, followed by a one-cycle
//               DONE state that pulses done_h.
// Ports       : clk_h            - clock (rising edge)
//               reset_l          - asynchronous active-low reset
//               start_h          - start request (sampled in IDLE only)
//               abort_h          - synchronous cancel in SHIFT/DONE
//               alushf_h[2:0]    - op code
//               count_h[CNTW-1:0]- number of single-bit steps
//               a_in_h, q_in_h   - operands
//               a_out_h, q_out_h - current A and Q registers
//               busy_h           - high in SHIFT and DONE
//               done_h           - one-cycle completion pulse
// Revision    : 1.0  initial release
// ============================================================================
module alkshfseq #(
  parameter int WIDTH = alk_pkg::c_WIDTH_DEFAULT,
  parameter int CNTW  = alk_pkg::c_CNTW_DEFAULT
) (
  input  logic             clk_h,
  input  logic             reset_l,
  input  logic             start_h,
  input  logic             abort_h,
  input  logic [2:0]       alushf_h,
  input  logic [CNTW-1:0]  count_h,
  input  logic [WIDTH-1:0] a_in_h,
  input  logic [WIDTH-1:0] q_in_h,
  output logic [WIDTH-1:0] a_out_h,
  output logic [WIDTH-1:0] q_out_h,
  output logic             busy_h,
  output logic             done_h
);

  import alk_pkg::*;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_q;
  logic [2:0]       r_op;
  logic [CNTW-1:0]  r_cnt;

  logic             w_load;
  logic             w_step;
  logic [WIDTH-1:0] w_a_step;
  logic [WIDTH-1:0] w_q_step;
  logic             w_sin_bit;

  logic             w_dir_right;
  logic             w_a_en;
  logic             w_q_en;
  sin_t             w_sin;
  logic             w_no_step;

  // Step controls come from the captured op, not the live input
  alkshfdec u_dec (
    .i_op        (r_op),
    .o_dir_right (w_dir_right),
    .o_a_en      (w_a_en),
    .o_q_en      (w_q_en),
    .o_sin       (w_sin),
    .o_no_step   (w_no_step)
  );

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_h or negedge reset_l) begin
    if (!reset_l) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state and datapath strobes
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_step      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        // abort_h is ignored here so a coincident start always wins
        if (start_h) begin
          w_load = 1'b1;
          if ((count_h == '0) || (alushf_h == c_OP_LOAD)) begin
            w_state_nxt = ST_DONE;
          end else begin
            w_state_nxt = ST_SHIFT;
          end
        end
      end
      ST_SHIFT: begin
        if (abort_h) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_step = ~w_no_step;
          // This edge performs the final step when one step remains
          if (r_cnt == {{(CNTW-1){1'b0}}, 1'b1}) begin
            w_state_nxt = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        // start_h is deliberately not sampled on the DONE-to-IDLE edge
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Single-bit shifter on A:Q
  // --------------------------------------------------------------------------
  always_comb begin
    case (w_sin)
      SIN_ZERO: w_sin_bit = 1'b0;
      SIN_ONE:  w_sin_bit = 1'b1;
      // Rotate feeds back the bit leaving the opposite end of the field
      SIN_WRAP: w_sin_bit = w_dir_right ? r_q[0] : r_a[WIDTH-1];
      SIN_SIGN: w_sin_bit = r_a[WIDTH-1];
      default:  w_sin_bit = 1'b0;
    endcase
  end

  always_comb begin
    w_a_step = r_a;
    w_q_step = r_q;
    if (!w_dir_right) begin
      if (w_a_en && w_q_en) begin
        w_a_step = {r_a[WIDTH-2:0], r_q[WIDTH-1]};
        w_q_step = {r_q[WIDTH-2:0], w_sin_bit};
      end else if (w_a_en) begin
        w_a_step = {r_a[WIDTH-2:0], w_sin_bit};
      end else if (w_q_en) begin
        w_q_step = {r_q[WIDTH-2:0], w_sin_bit};
      end
    end else begin
      if (w_a_en && w_q_en) begin
        w_a_step = {w_sin_bit, r_a[WIDTH-1:1]};
        w_q_step = {r_a[0], r_q[WIDTH-1:1]};
      end else if (w_a_en) begin
        w_a_step = {w_sin_bit, r_a[WIDTH-1:1]};
      end else if (w_q_en) begin
        w_q_step = {w_sin_bit, r_q[WIDTH-1:1]};
      end
    end
  end

  // --------------------------------------------------------------------------
  // Operand, op and count registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_h or negedge reset_l) begin
    if (!reset_l) begin
      r_a   <= '0;
      r_q   <= '0;
      r_op  <= c_OP_LOAD;
      r_cnt <= '0;
    end else if (w_load) begin
      r_a   <= a_in_h;
      r_q   <= q_in_h;
      r_op  <= alushf_h;
      r_cnt <= count_h;
    end else if (w_step) begin
      r_a   <= w_a_step;
      r_q   <= w_q_step;
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign a_out_h = r_a;
  assign q_out_h = r_q;
  assign busy_h  = (r_state == ST_SHIFT) || (r_state == ST_DONE);
  // An abort in DONE cancels the completion pulse for that cycle
  assign done_h  = (r_state == ST_DONE) && !abort_h;

endmodule : alkshfseq
`default_nettype wire

// File: tb/tb_alkshfseq.sv
`default_nettype none
// ============================================================================
// Module      : tb_alkshfseq
// Description : Self-checking bench for alkshfseq (WIDTH=32, CNTW=6).
//               Directed vector table, hand-written multi-cycle sequences
//               and randomized operations against a word-level model.
// Revision    : 1.0  initial release
// ============================================================================
module tb_alkshfseq;

  localparam int W = 32;
  localparam int C = 6;

  logic         clk_h = 1'b0;
  logic         reset_l = 1'b0;
  logic         start_h = 1'b0;
  logic         abort_h = 1'b0;
  logic [2:0]   alushf_h = 3'b0;
  logic [C-1:0] count_h = '0;
  logic [W-1:0] a_in_h = '0;
  logic [W-1:0] q_in_h = '0;
  logic [W-1:0] a_out_h;
  logic [W-1:0] q_out_h;
  logic         busy_h;
  logic         done_h;

  int checks = 0;
  int failures = 0;

  alkshfseq #(.WIDTH(W), .CNTW(C)) dut (
    .clk_h    (clk_h),
    .reset_l  (reset_l),
    .start_h  (start_h),
    .abort_h  (abort_h),
    .alushf_h (alushf_h),
    .count_h  (count_h),
    .a_in_h   (a_in_h),
    .q_in_h   (q_in_h),
    .a_out_h  (a_out_h),
    .q_out_h  (q_out_h),
    .busy_h   (busy_h),
    .done_h   (done_h)
  );

  always #5 clk_h = ~clk_h;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Word-level reference: A:Q handled as one 64-bit value
  function automatic logic [63:0] model(input logic [2:0] op, input int cnt,
                                        input logic [31:0] a, input logic [31:0] q);
    logic [63:0] v;
    logic [31:0] ma, mq;
    v = {a, q};
    for (int i = 0; i < cnt; i++) begin
      ma = v[63:32];
      mq = v[31:0];
      case (op)
        3'd1: v = (v << 1) | 64'd1;
        3'd2: v = v << 1;
        3'd3: v = (v << 1) | (v >> 63);
        3'd4: v = {ma, (mq << 1) | 32'd1};
        3'd5: v = {(ma << 1) | 32'd1, mq};
        3'd6: v = v >> 1;
        3'd7: v = $unsigned($signed(v) >>> 1);
        default: v = v;
      endcase
    end
    return v;
  endfunction

  // Called just after a negedge; returns just after a negedge in IDLE.
  task automatic run_op(input logic [2:0] op, input int cnt, input logic [31:0] a,
                        input logic [31:0] q, input logic ab,
                        output int lat, output int busy_cyc);
    alushf_h = op; count_h = C'(cnt); a_in_h = a; q_in_h = q;
    start_h = 1'b1; abort_h = ab;
    @(posedge clk_h); #1;
    start_h = 1'b0; abort_h = 1'b0;
    lat = -1; busy_cyc = 0;
    for (int k = 1; k <= 200; k++) begin
      @(negedge clk_h);
      if (busy_h) busy_cyc++;
      if (done_h) begin lat = k; break; end
    end
    @(negedge clk_h);
    chk("done_one_cycle", {63'd0, done_h}, 64'd0);
    chk("idle_after_done", {63'd0, busy_h}, 64'd0);
  endtask

  typedef struct {
    logic [2:0]  op;
    int          cnt;
    logic [31:0] a;
    logic [31:0] q;
    logic [31:0] ea;
    logic [31:0] eq;
    int          lat;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int lat, bc, dn;
    logic [2:0]  rop;
    int          rcnt;
    logic [31:0] ra, rq;
    logic [63:0] ev;

    vecs[0] = '{3'd3, 4,  32'h80000001, 32'h00000003, 32'h00000010, 32'h00000038, 5};
    vecs[1] = '{3'd2, 0,  32'h12345678, 32'h9ABCDEF0, 32'h12345678, 32'h9ABCDEF0, 1};
    vecs[2] = '{3'd1, 3,  32'h00000000, 32'h00000000, 32'h00000000, 32'h00000007, 4};
    vecs[3] = '{3'd7, 4,  32'h80000000, 32'h00000000, 32'hF8000000, 32'h00000000, 5};
    vecs[4] = '{3'd6, 63, 32'hFFFFFFFF, 32'h00000000, 32'h00000000, 32'h00000001, 64};
    vecs[5] = '{3'd0, 5,  32'hCAFEBABE, 32'h01234567, 32'hCAFEBABE, 32'h01234567, 1};
    vecs[6] = '{3'd4, 40, 32'hA5A5A5A5, 32'h00000000, 32'hA5A5A5A5, 32'hFFFFFFFF, 41};
    vecs[7] = '{3'd5, 33, 32'h00000005, 32'h5A5A5A5A, 32'hFFFFFFFF, 32'h5A5A5A5A, 34};

    // Reset state
    repeat (2) @(negedge clk_h);
    chk("reset_a", {32'd0, a_out_h}, 64'd0);
    chk("reset_q", {32'd0, q_out_h}, 64'd0);
    chk("reset_busy", {63'd0, busy_h}, 64'd0);
    chk("reset_done", {63'd0, done_h}, 64'd0);

    // Release and start on the very first rising edge
    reset_l = 1'b1;
    for (int i = 0; i < 8; i++) begin
      run_op(vecs[i].op, vecs[i].cnt, vecs[i].a, vecs[i].q, 1'b0, lat, bc);
      chk($sformatf("vec%0d_a", i), {32'd0, a_out_h}, {32'd0, vecs[i].ea});
      chk($sformatf("vec%0d_q", i), {32'd0, q_out_h}, {32'd0, vecs[i].eq});
      chk($sformatf("vec%0d_lat", i), 64'(lat), 64'(vecs[i].lat));
      chk($sformatf("vec%0d_busy", i), 64'(bc), 64'(vecs[i].lat));
    end

    // Outputs held after DONE while idle
    repeat (3) @(negedge clk_h);
    chk("hold_a", {32'd0, a_out_h}, {32'd0, vecs[7].ea});
    chk("hold_q", {32'd0, q_out_h}, {32'd0, vecs[7].eq});

    // abort_h coinciding with start in IDLE: start wins
    run_op(3'd2, 2, 32'h0, 32'h3, 1'b1, lat, bc);
    chk("abort_idle_q", {32'd0, q_out_h}, 64'h0000000C);
    chk("abort_idle_lat", 64'(lat), 64'd3);

    // Second start during busy is ignored
    alushf_h = 3'd4; count_h = 6'd2; a_in_h = 32'h0; q_in_h = 32'h100; start_h = 1'b1;
    @(posedge clk_h); #1;
    count_h = 6'd9; q_in_h = 32'hFFFF0000; a_in_h = 32'h1111;
    @(negedge clk_h);
    chk("ign_c1_done", {63'd0, done_h}, 64'd0);
    @(posedge clk_h); #1; start_h = 1'b0;
    @(negedge clk_h);
    chk("ign_c2_done", {63'd0, done_h}, 64'd0);
    @(negedge clk_h);
    chk("ign_c3_done", {63'd0, done_h}, 64'd1);
    chk("ign_q", {32'd0, q_out_h}, 64'h00000403);
    chk("ign_a", {32'd0, a_out_h}, 64'd0);
    @(negedge clk_h);
    chk("ign_idle", {63'd0, busy_h}, 64'd0);

    // start held high: DONE-to-IDLE edge refuses it, next IDLE accepts
    alushf_h = 3'd2; count_h = 6'd0; a_in_h = 32'h11; q_in_h = 32'h22; start_h = 1'b1;
    @(negedge clk_h);
    chk("hold_start_k1", {63'd0, done_h}, 64'd1);
    a_in_h = 32'h33;
    @(negedge clk_h);
    chk("hold_start_k2", {62'd0, busy_h, done_h}, 64'd0);
    @(negedge clk_h);
    chk("hold_start_k3", {63'd0, done_h}, 64'd1);
    chk("hold_start_a", {32'd0, a_out_h}, 64'h33);
    start_h = 1'b0;
    @(negedge clk_h);
    chk("hold_start_k4", {62'd0, busy_h, done_h}, 64'd0);

    // Abort in cycle 5 of a long shift
    alushf_h = 3'd2; count_h = 6'd40; a_in_h = 32'h0; q_in_h = 32'h1; start_h = 1'b1;
    @(posedge clk_h); #1; start_h = 1'b0;
    repeat (3) @(posedge clk_h);
    @(posedge clk_h); #1; abort_h = 1'b1;
    @(negedge clk_h);
    chk("abort_c5_done", {63'd0, done_h}, 64'd0);
    @(posedge clk_h); #1; abort_h = 1'b0;
    @(negedge clk_h);
    chk("abort_busy", {63'd0, busy_h}, 64'd0);
    chk("abort_q", {32'd0, q_out_h}, 64'h10);
    chk("abort_a", {32'd0, a_out_h}, 64'h0);
    dn = 0;
    for (int k = 0; k < 45; k++) begin
      @(negedge clk_h);
      if (done_h) dn++;
    end
    chk("abort_no_done", 64'(dn), 64'd0);
    chk("abort_q_held", {32'd0, q_out_h}, 64'h10);

    // Reset mid-operation
    alushf_h = 3'd2; count_h = 6'd40; a_in_h = 32'h1234; q_in_h = 32'h1; start_h = 1'b1;
    @(posedge clk_h); #1; start_h = 1'b0;
    repeat (3) @(negedge clk_h);
    #2 reset_l = 1'b0;
    #1;
    chk("rst_mid_a", {32'd0, a_out_h}, 64'd0);
    chk("rst_mid_q", {32'd0, q_out_h}, 64'd0);
    chk("rst_mid_busy_done", {62'd0, busy_h, done_h}, 64'd0);
    @(negedge clk_h);
    reset_l = 1'b1;
    dn = 0;
    for (int k = 0; k < 45; k++) begin
      @(negedge clk_h);
      if (done_h || busy_h) dn++;
    end
    chk("rst_mid_quiet", 64'(dn), 64'd0);

    // Randomized operations against the word-level model
    for (int i = 0; i < 40; i++) begin
      rop = 3'($urandom_range(0, 7));
      rcnt = ($urandom_range(0, 3) == 0) ? int'($urandom_range(32, 63))
                                         : int'($urandom_range(0, 12));
      ra = $urandom;
      rq = $urandom;
      ev = model(rop, (rop == 3'd0) ? 0 : rcnt, ra, rq);
      run_op(rop, rcnt, ra, rq, 1'b0, lat, bc);
      chk($sformatf("rnd%0d_op%0d_n%0d_aq", i, rop, rcnt), {a_out_h, q_out_h}, ev);
      chk($sformatf("rnd%0d_lat", i), 64'(lat),
          64'(((rcnt == 0) || (rop == 3'd0)) ? 1 : rcnt + 1));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_alkshfseq
`default_nettype wire

// File: doc/alkshfseq.md
ALKSHFSEQ -- requirements
Module: alkshfseq

Interface
REQ-001 Parameter WIDTH, default 32: width of the A and Q registers; legal 8..64.
REQ-002 Parameter CNTW, default 6: width of the shift count; SHALL be at least clog2(2*WIDTH).
REQ-003 clk_h  in  1: the only clock; all state SHALL change on its rising edge.
REQ-004 reset_l  in  1: asynchronous, active-low reset.
REQ-005 start_h  in  1: request a new operation; sampled only when busy_h is low.
REQ-006 abort_h  in  1: synchronous cancel of the operation in flight.
REQ-007 alushf_h  in  3: operation code, captured at start.
REQ-008 count_h  in  CNTW: number of single-bit steps, captured at start.
REQ-009 a_in_h, q_in_h  in  WIDTH each: operand values, captured at start.
REQ-010 a_out_h, q_out_h  out  WIDTH each: current A and Q register contents.
REQ-011 busy_h  out  1: high in the SHIFT and DONE states.
REQ-012 done_h  out  1: one-cycle completion pulse.

Function
REQ-013 The block SHALL have three states: IDLE, SHIFT and DONE.
REQ-014 In IDLE with start_h high, the block SHALL load A, Q, op and remaining count from the inputs on the same edge.
- At that edge it SHALL go to DONE if count_h=0 or op=000.
- Otherwise it SHALL go to SHIFT.
REQ-015 In each SHIFT cycle the block SHALL perform exactly one step and decrement the remaining count.
- It SHALL go to DONE on the edge that performs the last step.
REQ-016 DONE SHALL last exactly one cycle with done_h=1 and SHALL then return to IDLE.
- Latency from the start edge to done_h is N+1 cycles for a count of N (1 cycle for N=0).
REQ-017 Per-step operations (A:Q is the 2*WIDTH concatenation, A most significant):
- 000 LOAD: no step.
- 001 SHL1: A:Q shifted left, Q LSB takes 1.
- 010 SHF: A:Q shifted left, Q LSB takes 0.
- 011 ROT: A:Q rotated left, Q LSB takes old A MSB.
- 100 QSH1: Q shifted left with 1 in; A held.
- 101 ASH1: A shifted left with 1 in; Q held.
- 110 SHR: A:Q logical right shift, A MSB takes 0.
- 111 ASR: A:Q arithmetic right shift, A MSB replicated.
REQ-018 A count larger than the shifted width SHALL still run every step literally, with no saturation and no early exit.
REQ-019 start_h while busy_h=1 SHALL be ignored; the operands and the remaining count SHALL be unaffected.
REQ-020 abort_h=1 in SHIFT or DONE SHALL force IDLE on the next edge.
- A and Q SHALL hold their partial values.
- done_h SHALL NOT pulse.
- abort_h has priority over a step on that edge, so no step is performed.
REQ-021 abort_h in IDLE SHALL have no effect; if it coincides with start_h, start_h wins.
REQ-022 The DONE-to-IDLE edge SHALL NOT accept start_h.
- The earliest new start is sampled in the first IDLE cycle, so back-to-back operations are separated by one idle cycle.
REQ-023 a_out_h and q_out_h SHALL hold their values from DONE until the next accepted start.

Reset
REQ-024 While reset_l=0, the block SHALL immediately force:
- state to IDLE;
- A, Q, op and remaining count to 0;
- busy_h and done_h to 0.
REQ-025 Reset asserted mid-operation SHALL discard the operation with no done_h pulse.
REQ-026 After reset release, the first start_h SHALL be accepted on the first rising edge.

Structure
REQ-027 Package alk_pkg SHALL hold the op-code constants, the state encoding and the WIDTH and CNTW defaults.
REQ-028 A combinational sub-module, alkshfdec, SHALL decode the op code into step controls.
- Controls: direction, A-enable, Q-enable, shift-in source (0, 1, wrap, sign), no-step.
- alkshfseq SHALL instantiate it once, on the captured op register.
REQ-029 The step logic SHALL be a single one-bit shifter on A:Q; no barrel shifter is permitted.

Verification (WIDTH=32)
REQ-030 ROT, count 4, A=0x80000001, Q=0x00000003 -> A=0x00000010, Q=0x00000038, done_h exactly 5 cycles after the start edge.
REQ-031 SHF, count 0, A=0x12345678, Q=0x9ABCDEF0 -> outputs unchanged, done_h 1 cycle after start, busy_h high for 1 cycle.
REQ-032 SHL1, count 3, A=Q=0 -> Q=0x00000007, A=0; then ASR, count 4, A=0x80000000, Q=0 -> A=0xF8000000, Q=0.
REQ-033 QSH1, count 2, start_h pulsed again in cycle 1 with count 9 -> the second start is ignored, Q gains exactly two 1s, done_h at cycle 3.
REQ-034 SHF, count 40, A=0, Q=1:
- abort_h asserted in cycle 5 -> IDLE next edge, no done_h, Q=0x00000010 held.
- Separately, reset_l pulsed low mid-operation -> all outputs 0 immediately.
REQ-035 SHR, count 63, A=0xFFFFFFFF, Q=0 -> A=0, Q=0x00000001, done_h 64 cycles after start.
